// File: rtl/req_capture_latch.sv
// ---------------------------------------------------------------------------
// req_capture_latch
//
// Input stage in front of the 16-bit priority encoder. Each asynchronous
// request line is synchronised, then either its rising edge or its level is
// captured into a sticky pending bit. The pending vector feeds the encoder.
// The consumer clears serviced bits by index, or clears everything at once.
// A per-line overflow flag records edge events that arrived while the line
// was already pending, which means those events were lost.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   ena          capture enable; when low no pending bit is set
//   mode_level   0 = rising-edge capture, 1 = level capture
//   req_in       asynchronous request lines [N-1:0]
//   clr_valid    one-cycle strobe that clears pending[clr_index]
//   clr_index    index to clear; values >= N are ignored
//   clr_all      clears all pending and all overflow bits
//   pending      sticky pending vector (registered)
//   any_pending  registered OR of the pending vector
//   overflow     sticky per-line lost-event flags (registered)
// ---------------------------------------------------------------------------
module req_capture_latch #(
    parameter int unsigned N           = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mode_level,
    input  logic [N-1:0]     req_in,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_index,
    input  logic             clr_all,
    output logic [N-1:0]     pending,
    output logic             any_pending,
    output logic [N-1:0]     overflow
);

    // -----------------------------------------------------------------------
    // Synchroniser chain and edge-history flop. These run regardless of ena
    // so that re-enabling capture never sees a stale edge.
    // -----------------------------------------------------------------------
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] s;
    logic [N-1:0] s_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_d_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_d_q <= s;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Event detection and clear decode
    // -----------------------------------------------------------------------
    logic [N-1:0] ev;
    logic [N-1:0] set;
    logic [N-1:0] clr;

    always_comb begin
        ev  = '0;
        set = '0;
        if (mode_level) begin
            ev = s;
        end else begin
            ev = s & ~s_d_q;
        end
        set = ev & {N{ena}};
    end

    // Compare at 32 bits so an index >= N simply matches no line.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            clr[i] = clr_all | (clr_valid & (32'(clr_index) == 32'(i)));
        end
    end

    // -----------------------------------------------------------------------
    // Pending and overflow next state. Set wins over clear so an event racing
    // a clear is never dropped; such a race is also not counted as overflow.
    // Level mode re-asserts every cycle, so it never reports overflow.
    // -----------------------------------------------------------------------
    logic [N-1:0] pending_d;
    logic [N-1:0] pending_q;
    logic [N-1:0] overflow_d;
    logic [N-1:0] overflow_q;
    logic [N-1:0] ovf_set;
    logic         any_pending_q;

    always_comb begin
        pending_d  = '0;
        ovf_set    = '0;
        overflow_d = '0;
        pending_d  = set | (pending_q & ~clr);
        ovf_set    = set & pending_q & ~clr & {N{~mode_level}};
        overflow_d = ovf_set | (overflow_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            overflow_q    <= '0;
            any_pending_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            // Computed from the next value so it tracks |pending every cycle.
            any_pending_q <= |pending_d;
        end
    end

    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign any_pending = any_pending_q;

endmodule

// File: tb/tb_req_capture_latch.sv
module tb_req_capture_latch;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        mode_level;
    logic [15:0] req_in;
    logic        clr_valid;
    logic [3:0]  clr_index;
    logic        clr_all;
    logic [15:0] pending;
    logic        any_pending;
    logic [15:0] overflow;

    req_capture_latch #(
        .N          (16),
        .SYNC_STAGES(2),
        .IDX_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mode_level (mode_level),
        .req_in     (req_in),
        .clr_valid  (clr_valid),
        .clr_index  (clr_index),
        .clr_all    (clr_all),
        .pending    (pending),
        .any_pending(any_pending),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held across one rising edge + expected state after it.
    typedef struct {
        logic        en;
        logic        lvl;
        logic [15:0] req;
        logic        cv;
        logic [3:0]  ci;
        logic        ca;
        logic [15:0] ep;
        logic [15:0] eo;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic void add(input logic en, input logic lvl, input logic [15:0] req,
                                input logic cv, input logic [3:0] ci, input logic ca,
                                input logic [15:0] ep, input logic [15:0] eo);
        vec_t v;
        v.en = en; v.lvl = lvl; v.req = req; v.cv = cv; v.ci = ci; v.ca = ca;
        v.ep = ep; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] ep, input logic [15:0] eo);
        check({tag, " pending"}, pending, ep);
        check({tag, " overflow"}, overflow, eo);
        check({tag, " any_pending"}, {15'd0, any_pending}, {15'd0, (ep != 16'h0)});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- stimulus table ----------------
        //   en lvl req      cv ci  ca  pending  overflow
        // quiet after reset
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000);
        // edge capture of 0x8001, two-edge latency, no re-trigger
        add(1, 0, 16'h8001, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h8001, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h8001, 0, 0,  0, 16'h8001, 16'h0000);
        add(1, 0, 16'h8001, 0, 0,  0, 16'h8001, 16'h0000);
        // clear by index 15 then 0
        add(1, 0, 16'h8001, 1, 15, 0, 16'h0001, 16'h0000);
        add(1, 0, 16'h8001, 1, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h8001, 0, 0,  0, 16'h0000, 16'h0000);
        // bit 3: capture, toggle again while pending -> overflow, then clear
        add(1, 0, 16'h0008, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0008, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0008, 0, 0,  0, 16'h0008, 16'h0000);
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0008, 16'h0000);
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0008, 16'h0000);
        add(1, 0, 16'h0008, 0, 0,  0, 16'h0008, 16'h0000);
        add(1, 0, 16'h0008, 0, 0,  0, 16'h0008, 16'h0000);
        add(1, 0, 16'h0008, 0, 0,  0, 16'h0008, 16'h0008);
        add(1, 0, 16'h0008, 1, 3,  0, 16'h0000, 16'h0000);
        // bit 5: pend, then a new edge races clr_valid idx 5
        add(1, 0, 16'h0020, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  0, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  0, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 1, 5,  0, 16'h0020, 16'h0000);
        // bit 5 edge races clr_all, then clr_all alone clears
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  0, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  0, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  1, 16'h0020, 16'h0000);
        add(1, 0, 16'h0020, 0, 0,  1, 16'h0000, 16'h0000);
        // level mode on line 8: set wins over a clear while the line is high
        add(1, 0, 16'h0100, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0100, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 1, 16'h0100, 0, 0,  0, 16'h0100, 16'h0000);
        add(1, 1, 16'h0100, 1, 8,  0, 16'h0100, 16'h0000);
        // ena low: clear honoured, nothing re-sets
        add(0, 1, 16'h0100, 1, 8,  0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0100, 0, 0,  0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0100, 0, 0,  0, 16'h0000, 16'h0000);
        // re-enable in level mode, then switch to edge mode: bit retained
        add(1, 1, 16'h0100, 0, 0,  0, 16'h0100, 16'h0000);
        add(1, 0, 16'h0100, 0, 0,  0, 16'h0100, 16'h0000);
        add(1, 0, 16'h0000, 1, 8,  0, 16'h0000, 16'h0000);
        // edge on line 9 while ena low is discarded, not deferred
        add(0, 0, 16'h0200, 0, 0,  0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0200, 0, 0,  0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0200, 0, 0,  0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0200, 0, 0,  0, 16'h0000, 16'h0000);
        // level mode while pending never flags overflow
        add(1, 1, 16'h0200, 0, 0,  0, 16'h0200, 16'h0000);
        add(1, 1, 16'h0200, 0, 0,  0, 16'h0200, 16'h0000);
        add(1, 0, 16'h0000, 0, 0,  1, 16'h0000, 16'h0000);

        // ---------------- reset ----------------
        rst_n      = 1'b0;
        ena        = 1'b1;
        mode_level = 1'b0;
        req_in     = '0;
        clr_valid  = 1'b0;
        clr_index  = '0;
        clr_all    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table run ----------------
        foreach (vecs[r]) begin
            ena        = vecs[r].en;
            mode_level = vecs[r].lvl;
            req_in     = vecs[r].req;
            clr_valid  = vecs[r].cv;
            clr_index  = vecs[r].ci;
            clr_all    = vecs[r].ca;
            cycle();
            check_all($sformatf("row%0d", r), vecs[r].ep, vecs[r].eo);
        end

        // ---------------- asynchronous reset mid-operation ----------------
        ena = 1'b1; mode_level = 1'b0; clr_valid = 1'b0; clr_all = 1'b0;
        req_in = 16'h0004;
        repeat (3) cycle();
        check_all("pre_rst_pend", 16'h0004, 16'h0000);
        req_in = 16'h0000;
        repeat (2) cycle();
        req_in = 16'h0004;
        repeat (3) cycle();
        check_all("pre_rst_ovf", 16'h0004, 16'h0004);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 16'h0000);

        // ---------------- line held high through reset release ----------------
        #2;
        rst_n = 1'b1;
        cycle();
        check_all("rel_edge1", 16'h0000, 16'h0000);
        repeat (2) cycle();
        check_all("rel_edge3", 16'h0004, 16'h0000);
        repeat (4) cycle();
        check_all("rel_held", 16'h0004, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
